// File: rtl/mem_dual_arbiter.sv
// mem_dual_arbiter: round-robin arbiter granting up to two requesters per cycle onto a dual-port RAM.
module mem_dual_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int NREQ = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rvalid,
  output logic [WIDTH-1:0]      rdata,
  output logic [WIDTH-1:0]      mem_data_0,
  output logic [WIDTH-1:0]      mem_data_1,
  output logic [AW-1:0]         mem_address_0,
  output logic [AW-1:0]         mem_address_1,
  output logic                  mem_wren_0,
  output logic                  mem_wren_1,
  input  logic [WIDTH-1:0]      mem_q_0,
  input  logic [WIDTH-1:0]      mem_q_1
);
  logic [IW-1:0] ptr_q, ptr_d, rv_id0_q, rv_id0_d, rv_id1_q, rv_id1_d;
  logic rv_en0_q, rv_en0_d, rv_en1_q, rv_en1_d;
  logic a_ok, b_ok;
  logic [IW-1:0] a_idx, b_idx, idx;
  logic [IW:0] sum;

  function automatic logic [IW-1:0] inc(input logic [IW-1:0] x);
    return (x == IW'(NREQ - 1)) ? '0 : x + 1'b1;
  endfunction

  // B must differ in address from A and at least one of them must write,
  // which also keeps at most one read returning per cycle.
  always_comb begin
    a_ok = 1'b0;
    b_ok = 1'b0;
    a_idx = '0;
    b_idx = '0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      idx = IW'(sum >= (IW+1)'(NREQ) ? sum - (IW+1)'(NREQ) : sum);
      if (req[idx] && !rst) begin
        if (!a_ok) begin
          a_ok = 1'b1;
          a_idx = idx;
        end else if (!b_ok && (req_we[idx] || req_we[a_idx]) &&
                     req_addr[idx*AW +: AW] != req_addr[a_idx*AW +: AW]) begin
          b_ok = 1'b1;
          b_idx = idx;
        end
      end
    end
  end

  always_comb begin
    gnt = (a_ok ? NREQ'(1) << a_idx : '0) | (b_ok ? NREQ'(1) << b_idx : '0);
    mem_wren_0 = a_ok && req_we[a_idx];
    mem_wren_1 = b_ok && req_we[b_idx];
    mem_address_0 = a_ok ? req_addr[a_idx*AW +: AW] : '0;
    mem_address_1 = b_ok ? req_addr[b_idx*AW +: AW] : '0;
    mem_data_0 = a_ok ? req_wdata[a_idx*WIDTH +: WIDTH] : '0;
    mem_data_1 = b_ok ? req_wdata[b_idx*WIDTH +: WIDTH] : '0;
    ptr_d = b_ok ? inc(b_idx) : a_ok ? inc(a_idx) : ptr_q;
    rv_en0_d = a_ok && !req_we[a_idx];
    rv_en1_d = b_ok && !req_we[b_idx];
    rv_id0_d = a_idx;
    rv_id1_d = b_idx;
    rvalid = (rv_en0_q ? NREQ'(1) << rv_id0_q : '0) | (rv_en1_q ? NREQ'(1) << rv_id1_q : '0);
    rdata = rv_en0_q ? mem_q_0 : rv_en1_q ? mem_q_1 : '0;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      rv_id0_q <= '0;
      rv_id1_q <= '0;
      rv_en0_q <= 1'b0;
      rv_en1_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      rv_id0_q <= rv_id0_d;
      rv_id1_q <= rv_id1_d;
      rv_en0_q <= rv_en0_d;
      rv_en1_q <= rv_en1_d;
    end
  end
endmodule

// File: tb/tb_mem_dual_arbiter.sv
// tb_mem_dual_arbiter: directed and random checks of mem_dual_arbiter against a rule-level model.
module tb_mem_dual_arbiter;
  localparam int W = 8, D = 64, N = 4, AW = 6;
  logic clock = 0, rst = 1;
  logic [N-1:0] req = '0, req_we = '0, gnt, rvalid;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*W-1:0] req_wdata = '0;
  logic [W-1:0] rdata, mem_data_0, mem_data_1, mem_q_0, mem_q_1;
  logic [AW-1:0] mem_address_0, mem_address_1;
  logic mem_wren_0, mem_wren_1;
  logic [W-1:0] mem [D] = '{default: '0};
  logic [W-1:0] ref_mem [D] = '{default: '0};
  int checks = 0, errors = 0, ptr_m = 0;
  logic [N-1:0] exp_rv = '0;
  logic [W-1:0] exp_rd = '0;
  logic [N-1:0] g, rv;
  logic [W-1:0] rd;

  mem_dual_arbiter #(.WIDTH(W), .DEPTH(D), .NREQ(N)) dut (
    .clock(clock), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_data_0(mem_data_0), .mem_data_1(mem_data_1),
    .mem_address_0(mem_address_0), .mem_address_1(mem_address_1),
    .mem_wren_0(mem_wren_0), .mem_wren_1(mem_wren_1),
    .mem_q_0(mem_q_0), .mem_q_1(mem_q_1));

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_wren_0) mem[mem_address_0] <= mem_data_0;
    if (mem_wren_1) mem[mem_address_1] <= mem_data_1;
    mem_q_0 <= mem[mem_address_0];
    mem_q_1 <= mem[mem_address_1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] ad(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  function automatic logic [W-1:0] wd(input int i);
    return req_wdata[i*W +: W];
  endfunction

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
    req[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*W +: W] = d;
  endtask

  // One clock cycle: check DUT against the model at the falling edge, then advance the model.
  task automatic step(output logic [N-1:0] go, output logic [N-1:0] rvo, output logic [W-1:0] rdo);
    int order[$];
    int a, b;
    logic [N-1:0] eg, nrv;
    @(negedge clock);
    a = -1;
    b = -1;
    eg = '0;
    if (!rst) begin
      for (int k = 0; k < N; k++) if (req[(ptr_m + k) % N]) order.push_back((ptr_m + k) % N);
      if (order.size() > 0) a = order[0];
      for (int j = 1; j < order.size(); j++)
        if (b < 0 && (req_we[order[j]] || req_we[a]) && ad(order[j]) != ad(a)) b = order[j];
      if (a >= 0) eg[a] = 1'b1;
      if (b >= 0) eg[b] = 1'b1;
    end
    go = gnt;
    rvo = rvalid;
    rdo = rdata;
    chk("gnt", gnt, eg);
    chk("wren0", mem_wren_0, a >= 0 && req_we[a]);
    chk("wren1", mem_wren_1, b >= 0 && req_we[b]);
    chk("addr0", mem_address_0, a >= 0 ? ad(a) : 0);
    chk("addr1", mem_address_1, b >= 0 ? ad(b) : 0);
    chk("data0", mem_data_0, a >= 0 ? wd(a) : 0);
    chk("data1", mem_data_1, b >= 0 ? wd(b) : 0);
    chk("rvalid", rvalid, rst ? '0 : exp_rv);
    if (rst || exp_rv != 0) chk("rdata", rdata, rst ? '0 : exp_rd);
    if (rst) begin
      ptr_m = 0;
      exp_rv = '0;
    end else begin
      nrv = '0;
      if (a >= 0 && !req_we[a]) begin nrv[a] = 1'b1; exp_rd = ref_mem[ad(a)]; end
      if (b >= 0 && !req_we[b]) begin nrv[b] = 1'b1; exp_rd = ref_mem[ad(b)]; end
      exp_rv = nrv;
      if (a >= 0 && req_we[a]) ref_mem[ad(a)] = wd(a);
      if (b >= 0 && req_we[b]) ref_mem[ad(b)] = wd(b);
      if (a >= 0) ptr_m = ((b >= 0 ? b : a) + 1) % N;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    req = '1;
    req_we = '1;
    step(g, rv, rd);
    chk("reset_gnt", g, 0);
    chk("reset_rvalid", rv, 0);
    rst = 0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i), W'(8'h10 + i));
    step(g, rv, rd); chk("rr_pair0", g, 4'b0011);
    step(g, rv, rd); chk("rr_pair1", g, 4'b1100);
    step(g, rv, rd); chk("rr_pair2", g, 4'b0011);
    for (int i = 0; i < N; i++) chk("rr_mem", mem[i], 8'h10 + i);
    req = '0;
    set_req(0, 1'b1, 6'd5, 8'hA5);
    step(g, rv, rd); chk("preload_gnt", g, 4'b0001);
    req = '0;
    set_req(2, 1'b0, 6'd5, 8'h00);
    step(g, rv, rd); chk("rd_gnt", g, 4'b0100);
    req = '0;
    step(g, rv, rd); chk("rd_rvalid", rv, 4'b0100); chk("rd_rdata", rd, 8'hA5);
    step(g, rv, rd); chk("rd_rvalid_once", rv, 4'b0000);
    set_req(0, 1'b1, 6'd9, 8'h3C);
    set_req(1, 1'b0, 6'd9, 8'h00);
    step(g, rv, rd); chk("conf_gnt0", g, 4'b0001);
    req[0] = 1'b0;
    step(g, rv, rd); chk("conf_gnt1", g, 4'b0010);
    req = '0;
    step(g, rv, rd); chk("conf_rvalid", rv, 4'b0010); chk("conf_rdata", rd, 8'h3C);
    set_req(0, 1'b1, 6'd20, 8'h00);
    step(g, rv, rd); chk("pair_setup", g, 4'b0001);
    req = '0;
    set_req(1, 1'b0, 6'd30, 8'h00);
    set_req(2, 1'b1, 6'd31, 8'h77);
    set_req(3, 1'b0, 6'd32, 8'h00);
    step(g, rv, rd); chk("pair_gnt0", g, 4'b0110);
    req[1] = 1'b0;
    req[2] = 1'b0;
    step(g, rv, rd); chk("pair_gnt1", g, 4'b1000); chk("pair_rv0", rv, 4'b0010);
    req = '0;
    step(g, rv, rd); chk("pair_rv1", rv, 4'b1000);
    set_req(1, 1'b0, 6'd30, 8'h00);
    step(g, rv, rd); chk("mid_gnt", g, 4'b0010);
    req = '0;
    rst = 1;
    step(g, rv, rd); chk("mid_rvalid", rv, 4'b0000); chk("mid_gnt_rst", g, 4'b0000);
    rst = 0;
    set_req(0, 1'b0, 6'd1, 8'h00);
    set_req(2, 1'b0, 6'd2, 8'h00);
    step(g, rv, rd); chk("mid_ptr", g, 4'b0001);
    req = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom), AW'($urandom_range(0, 7)), W'($urandom));
      step(g, rv, rd);
      chk("rand_rv_onehot", $countones(rv) <= 1, 1);
      req = req & ~g;
    end
    req = '0;
    step(g, rv, rd);
    step(g, rv, rd);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
